cache_bus_arbiter: RTL

//  Shares one word-wide memory port between NUM_PORTS cache controllers (I-cache, D-cache).

---
 rtl/cache_bus_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: shares one memory port between cache controllers.
// One transaction in flight; round-robin or fixed priority; watchdog abort.
module cache_bus_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter bit FIXED_PRIORITY = 1'b0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_PORTS-1:0]   req_i,
  input  logic [32*NUM_PORTS-1:0] addr_i,
  input  logic [32*NUM_PORTS-1:0] wdata_i,
  input  logic [NUM_PORTS-1:0]   we_i,
  input  logic [4*NUM_PORTS-1:0] be_i,
  output logic [NUM_PORTS-1:0]   gnt_o,
  output logic [NUM_PORTS-1:0]   rvalid_o,
  output logic [31:0]            rdata_o,
  output logic [NUM_PORTS-1:0]   error_o,
  output logic                   mem_req_o,
  output logic [31:0]            mem_addr_o,
  output logic [31:0]            mem_wdata_o,
  output logic                   mem_we_o,
  output logic [3:0]             mem_be_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [31:0]            mem_rdata_i,
  input  logic                   mem_error_i
);

  localparam int OW = $clog2(NUM_PORTS);
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ARB_REQ  = 2'd1;
  localparam logic [1:0] WAIT_RSP = 2'd2;

  logic [1:0]    state;
  logic [OW-1:0] owner;
  logic [OW-1:0] rr_ptr;
  logic [OW-1:0] winner;
  logic [OW-1:0] owner_nxt;
  logic [OW-1:0] sel;
  logic [TW-1:0] timer;
  logic          timeout;
  int            base;

  // Pick the first requester at or after the search start
  always_comb begin
    winner = '0;
    sel    = '0;
    base   = 0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      base = FIXED_PRIORITY ? i : (int'(rr_ptr) + i) % NUM_PORTS;
      sel  = OW'(base);
      if (req_i[sel]) winner = sel;
    end
  end

  // Port after the current owner, wrapping to 0
  always_comb begin
    owner_nxt = owner + 1'b1;
    if (owner == OW'(NUM_PORTS - 1)) owner_nxt = '0;
  end

  // Watchdog fires on the last allowed wait cycle with no response
  always_comb begin
    timeout = 1'b0;
    if (TIMEOUT_CYCLES != 0 && state == WAIT_RSP)
      timeout = (timer == TW'(TIMEOUT_CYCLES - 1)) && !mem_rvalid_i;
  end

  // Transaction sequencing, owner latch and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      timer  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_i) begin
            owner <= winner;
            state <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (!req_i[owner]) begin
            state <= IDLE;
          end else if (mem_gnt_i) begin
            state <= WAIT_RSP;
            timer <= '0;
          end
        end
        WAIT_RSP: begin
          timer <= timer + 1'b1;
          if (mem_rvalid_i || timeout) begin
            rr_ptr <= owner_nxt;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Route the owner onto the bus and the response back to it
  always_comb begin
    gnt_o       = '0;
    rvalid_o    = '0;
    error_o     = '0;
    rdata_o     = '0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    case (state)
      ARB_REQ: begin
        mem_req_o     = req_i[owner];
        mem_addr_o    = addr_i[int'(owner)*32 +: 32];
        mem_wdata_o   = wdata_i[int'(owner)*32 +: 32];
        mem_we_o      = we_i[owner];
        mem_be_o      = be_i[int'(owner)*4 +: 4];
        gnt_o[owner]  = mem_gnt_i & req_i[owner];
      end
      WAIT_RSP: begin
        rvalid_o[owner] = mem_rvalid_i | timeout;
        error_o[owner]  = mem_error_i | timeout;
        rdata_o         = timeout ? '0 : mem_rdata_i;
      end
      default: ;
    endcase
  end

endmodule
